// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port I/D arbiter and access sequencer for the memory map
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   i_req_* / i_rsp_*    fetch port: read-only requests, word responses
//   d_req_* / d_rsp_*    load/store port: d_req_be != 0 is a store, 0 is a load
//   mem_*                memory map: address, write data, byte enables, read data
module mem_arbiter #(
  parameter bit DATA_PRIORITY = 1'b0  // 0: round-robin on ties, 1: D wins ties
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_be,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic        owner_q;       // 1 = D port owns the transaction in flight
  logic        last_grant_q;  // 1 = D port won the most recent grant
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;

  logic in_idle;
  logic pick_dport;
  logic i_accept;
  logic d_accept;

  always_comb begin
    in_idle    = (state_q == S_IDLE);
    // On a tie, round-robin hands the slot to the port that did not win last.
    pick_dport = d_req_valid && (!i_req_valid || DATA_PRIORITY || !last_grant_q);
    // Readies are forced low while reset is asserted, not just after the next edge.
    i_accept   = reset_n && in_idle && i_req_valid && !pick_dport;
    d_accept   = reset_n && in_idle && pick_dport;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_accept || d_accept) begin
            state_q      <= S_ACCESS;
            owner_q      <= d_accept;
            last_grant_q <= d_accept;
            addr_q       <= d_accept ? d_req_addr : i_req_addr;
            wdata_q      <= d_accept ? d_req_wdata : '0;
            be_q         <= d_accept ? d_req_be : 4'h0;
          end
        end
        S_ACCESS: state_q <= S_WAIT;
        S_WAIT: begin
          // RAM data is registered at the ACCESS edge; MMIO data is combinational
          // on the held address. Both are valid here.
          rdata_q <= (be_q == 4'h0) ? mem_read_data : '0;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (owner_q ? d_rsp_ready : i_rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_resp;
  assign in_resp = (state_q == S_RESP);

  assign i_req_ready      = i_accept;
  assign d_req_ready      = d_accept;
  assign i_rsp_valid      = in_resp && !owner_q;
  assign d_rsp_valid      = in_resp && owner_q;
  assign i_rsp_data       = i_rsp_valid ? rdata_q : '0;
  assign d_rsp_data       = d_rsp_valid ? rdata_q : '0;
  // Address is held in every state so registered and combinational reads both see it.
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = (state_q == S_ACCESS) ? be_q : 4'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam logic [31:0] LEDR_ADDR = 32'h1000_0000;
  localparam logic [31:0] P_XOR     = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic mem_init;

  // round-robin instance
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_be, mem_write_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  // fixed-priority instance
  logic        p_i_req_valid, p_i_req_ready, p_i_rsp_valid, p_i_rsp_ready;
  logic [31:0] p_i_req_addr, p_i_rsp_data;
  logic        p_d_req_valid, p_d_req_ready, p_d_rsp_valid, p_d_rsp_ready;
  logic [31:0] p_d_req_addr, p_d_req_wdata, p_d_rsp_data;
  logic [3:0]  p_d_req_be, p_mem_write_enable;
  logic [31:0] p_mem_address, p_mem_write_data, p_mem_read_data;

  mem_arbiter #(.DATA_PRIORITY(1'b0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  mem_arbiter #(.DATA_PRIORITY(1'b1)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(p_i_req_valid), .i_req_ready(p_i_req_ready), .i_req_addr(p_i_req_addr),
    .i_rsp_valid(p_i_rsp_valid), .i_rsp_ready(p_i_rsp_ready), .i_rsp_data(p_i_rsp_data),
    .d_req_valid(p_d_req_valid), .d_req_ready(p_d_req_ready), .d_req_addr(p_d_req_addr),
    .d_req_wdata(p_d_req_wdata), .d_req_be(p_d_req_be),
    .d_rsp_valid(p_d_rsp_valid), .d_rsp_ready(p_d_rsp_ready), .d_rsp_data(p_d_rsp_data),
    .mem_address(p_mem_address), .mem_write_data(p_mem_write_data),
    .mem_write_enable(p_mem_write_enable), .mem_read_data(p_mem_read_data)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(input int idx);
    return (idx == 4) ? 32'hDEAD_BEEF : ((32'(idx) * 32'h0101_0101) ^ 32'hC3C3_0000);
  endfunction

  // memory map behind u_rr: registered RAM read, combinational LEDR read
  logic [31:0] ram [256];
  logic [9:0]  ledr;
  logic [31:0] ram_rd_q;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
      ledr <= '0;
    end else begin
      ram_rd_q <= ram[mem_address[9:2]];
      if (mem_address == LEDR_ADDR) begin
        if (mem_write_enable[0]) ledr[7:0] <= mem_write_data[7:0];
        if (mem_write_enable[1]) ledr[9:8] <= mem_write_data[9:8];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_write_enable[b]) ram[mem_address[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
    end
  end
  assign mem_read_data = (mem_address == LEDR_ADDR) ? {22'd0, ledr} : ram_rd_q;

  // memory behind u_fp: registered read returning a function of the address
  logic [31:0] p_rd_q;
  always @(posedge clk) p_rd_q <= p_mem_address ^ P_XOR;
  assign p_mem_read_data = p_rd_q;

  // transaction-level reference memory
  logic [31:0] ref_ram [256];
  logic [9:0]  ref_ledr;

  task automatic ref_access(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                            output logic [31:0] rsp);
    logic [31:0] old, mask, nw;
    int idx;
    idx  = int'((a >> 2) & 32'd255);
    old  = (a == LEDR_ADDR) ? {22'd0, ref_ledr} : ref_ram[idx];
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    nw   = (old & ~mask) | (w & mask);
    if (be == 4'h0) begin
      rsp = old;
    end else begin
      rsp = '0;
      if (a == LEDR_ADDR) ref_ledr = nw[9:0];
      else ref_ram[idx] = nw;
    end
  endtask

  // arbiter model for u_rr: one transaction at a time, response 3 cycles after grant
  bit          busy = 1'b0;
  bit          m_owner_d;
  bit          m_last_d = 1'b1;
  bit          m_pick_d;
  int          m_cnt;
  logic [31:0] m_addr, m_wdata, m_exp;
  logic [3:0]  m_be;
  bit          grants[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      busy     = 1'b0;
      m_last_d = 1'b1;
    end else if (busy) begin
      m_cnt++;
      if (m_cnt == 3) ref_access(m_addr, m_wdata, m_be, m_exp);
      check_eq("busy_i_req_ready", 32'(i_req_ready), 32'd0);
      check_eq("busy_d_req_ready", 32'(d_req_ready), 32'd0);
      check_eq("mem_address", mem_address, m_addr);
      check_eq("mem_write_enable", 32'(mem_write_enable), (m_cnt == 1) ? 32'(m_be) : 32'd0);
      if (m_cnt == 1 && m_be != 4'h0) check_eq("mem_write_data", mem_write_data, m_wdata);
      check_eq("i_rsp_valid", 32'(i_rsp_valid), 32'(m_cnt >= 3 && !m_owner_d));
      check_eq("d_rsp_valid", 32'(d_rsp_valid), 32'(m_cnt >= 3 && m_owner_d));
      if (m_cnt >= 3) begin
        if (m_owner_d) check_eq("d_rsp_data", d_rsp_data, m_exp);
        else check_eq("i_rsp_data", i_rsp_data, m_exp);
        if (m_owner_d ? d_rsp_ready : i_rsp_ready) busy = 1'b0;
      end
    end else begin
      m_pick_d = d_req_valid && (!i_req_valid || !m_last_d);
      check_eq("idle_i_req_ready", 32'(i_req_ready), 32'(i_req_valid && !m_pick_d));
      check_eq("idle_d_req_ready", 32'(d_req_ready), 32'(m_pick_d));
      check_eq("idle_mem_we", 32'(mem_write_enable), 32'd0);
      check_eq("idle_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
      if (i_req_valid || d_req_valid) begin
        busy      = 1'b1;
        m_cnt     = 0;
        m_owner_d = m_pick_d;
        m_last_d  = m_pick_d;
        m_addr    = m_pick_d ? d_req_addr : i_req_addr;
        m_wdata   = m_pick_d ? d_req_wdata : 32'd0;
        m_be      = m_pick_d ? d_req_be : 4'h0;
        grants.push_back(m_pick_d);
      end
    end
  end

  task automatic do_i(input logic [31:0] a, output logic [31:0] r);
    int t;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    t = 0;
    do begin @(negedge clk); t++; end while (!i_req_ready && t < 100);
    check_eq("i_req_handshake", 32'(i_req_ready), 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(i_rsp_valid && i_rsp_ready) && t < 100);
    check_eq("i_rsp_handshake", 32'(i_rsp_valid && i_rsp_ready), 32'd1);
    r = i_rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic do_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                      output logic [31:0] r);
    int t;
    d_req_valid = 1'b1;
    d_req_addr  = a;
    d_req_wdata = w;
    d_req_be    = be;
    t = 0;
    do begin @(negedge clk); t++; end while (!d_req_ready && t < 100);
    check_eq("d_req_handshake", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(d_rsp_valid && d_rsp_ready) && t < 100);
    check_eq("d_rsp_handshake", 32'(d_rsp_valid && d_rsp_ready), 32'd1);
    r = d_rsp_data;
    @(posedge clk); #1;
  endtask

  // random response backpressure on u_rr
  initial begin
    i_rsp_ready = 1'b1;
    d_rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int          t;
    logic [31:0] r, r_i, r_d, a, held;
    logic [3:0]  be;

    reset_n = 1'b0;  mem_init = 1'b1;
    i_req_valid = 1'b1; i_req_addr = '0;
    d_req_valid = 1'b1; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;
    p_i_req_valid = 1'b1; p_i_req_addr = '0; p_i_rsp_ready = 1'b1;
    p_d_req_valid = 1'b1; p_d_req_addr = '0; p_d_req_wdata = '0; p_d_req_be = '0;
    p_d_rsp_ready = 1'b1;
    for (int k = 0; k < 256; k++) ref_ram[k] = init_word(k);
    ref_ledr = '0;

    // reset state, with requests pending on both ports
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_i_req_ready", 32'(i_req_ready), 32'd0);
    check_eq("rst_d_req_ready", 32'(d_req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
    check_eq("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check_eq("rst_mem_address", mem_address, 32'd0);
    check_eq("rst_p_ready", 32'({p_i_req_ready, p_d_req_ready}), 32'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    p_i_req_valid = 1'b0; p_d_req_valid = 1'b0;
    mem_init = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // single load
    do_d(32'h0000_0010, 32'd0, 4'h0, r);
    check_eq("load_0x10", r, 32'hDEAD_BEEF);

    // partial store then fetch of the same word
    do_d(32'h0000_0020, 32'h1234_5678, 4'b0011, r);
    check_eq("store_ack_data", r, 32'd0);
    do_i(32'h0000_0020, r);
    held = init_word(8);
    check_eq("fetch_after_store", r, {held[31:16], 16'h5678});

    // LEDR store then load
    do_d(LEDR_ADDR, 32'h0000_03FF, 4'hF, r);
    do_d(LEDR_ADDR, 32'd0, 4'h0, r);
    check_eq("ledr_load", r, 32'h0000_03FF);

    // reset asserted during the ACCESS cycle of a full-word store
    d_req_valid = 1'b1; d_req_addr = 32'h30; d_req_wdata = 32'hFFFF_FFFF; d_req_be = 4'hF;
    t = 0;
    do begin @(negedge clk); t++; end while (!d_req_ready && t < 100);
    check_eq("rst_store_handshake", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_we_drop", 32'(mem_write_enable), 32'd0);
    check_eq("rst_addr_drop", mem_address, 32'd0);
    check_eq("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_d(32'h30, 32'd0, 4'h0, r);
    check_eq("rst_no_write", r, init_word(12));

    // contention under round-robin: last grant was D, so I goes first
    grants.delete();
    fork
      for (int k = 0; k < 4; k++) do_i(32'h40 + 32'(4 * k), r_i);
      for (int k = 0; k < 4; k++) do_d(32'h80 + 32'(4 * k), 32'd0, 4'h0, r_d);
    join
    check_eq("rr_grant_count", 32'(grants.size()), 32'd8);
    if (grants.size() >= 4) begin
      check_eq("rr_grant0", 32'(grants[0]), 32'd0);
      check_eq("rr_grant1", 32'(grants[1]), 32'd1);
      check_eq("rr_grant2", 32'(grants[2]), 32'd0);
      check_eq("rr_grant3", 32'(grants[3]), 32'd1);
    end

    // random mixed traffic
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_i(32'($urandom_range(0, 255)) << 2, r_i);
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        a  = ($urandom_range(0, 7) == 0) ? LEDR_ADDR : (32'($urandom_range(0, 255)) << 2);
        be = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        do_d(a, $urandom, be, r_d);
      end
    join

    // fixed priority: I stays valid, D keeps re-requesting and always wins
    p_i_req_valid = 1'b1; p_i_req_addr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      p_d_req_valid = 1'b1; p_d_req_addr = 32'h100 + 32'(4 * k);
      p_d_rsp_ready = (k != 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!p_d_req_ready && t < 50);
      check_eq("p_d_grant", 32'(p_d_req_ready), 32'd1);
      check_eq("p_i_lose", 32'(p_i_req_ready), 32'd0);
      @(posedge clk); #1;
      p_d_req_valid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!p_d_rsp_valid && t < 50);
      check_eq("p_d_rsp_data", p_d_rsp_data, (32'h100 + 32'(4 * k)) ^ P_XOR);
      if (k == 1) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check_eq("p_bp_valid", 32'(p_d_rsp_valid), 32'd1);
          check_eq("p_bp_data", p_d_rsp_data, 32'h104 ^ P_XOR);
          check_eq("p_bp_no_grant", 32'({p_i_req_ready, p_d_req_ready, p_i_rsp_valid}), 32'd0);
          check_eq("p_bp_mem", p_mem_write_data | 32'(p_mem_write_enable), 32'd0);
        end
        @(posedge clk); #1;
        p_d_rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("p_bp_release", 32'(p_d_rsp_valid), 32'd1);
      end
      @(posedge clk); #1;
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!p_i_req_ready && t < 50);
    check_eq("p_i_grant", 32'(p_i_req_ready), 32'd1);
    @(posedge clk); #1;
    p_i_req_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!p_i_rsp_valid && t < 50);
    check_eq("p_i_rsp_data", p_i_rsp_data, 32'h40 ^ P_XOR);
    check_eq("p_d_idle", 32'(p_d_rsp_valid), 32'd0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
